stream_arb2x1: RTL and testbench

STREAM_ARB2X1 -- requirements
Module: stream_arb2x1

---
 rtl/stream_arb2x1.sv | 86 ++++++++
 tb/tb_stream_arb2x1.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb2x1.sv
// Two-input valid/ready stream arbiter feeding a single-entry output register.
// Ties are broken by a two-state round-robin FSM, so the port that was just
// served loses the next tie. An output drain and a new accept can happen in
// the same cycle, which gives one beat per cycle throughput.
module stream_arb2x1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_t;

  prio_t            state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;

  logic             can_accept;
  logic             grant_any;
  logic             grant_idx;
  logic             accept;

  // Output slot is free when it is empty or being drained this cycle.
  assign can_accept = !out_valid_q | out_ready;

  // Grant selection: a lone requester wins; on a tie the FSM state decides.
  always_comb begin
    grant_any = in0_valid | in1_valid;
    grant_idx = in1_valid & (!in0_valid | (state_q == PRIO1));
  end

  // Ready only ever goes to the granted port, and is held low during reset.
  assign in0_ready = grant_any & !grant_idx & can_accept & !rst;
  assign in1_ready = grant_any &  grant_idx & can_accept & !rst;
  assign accept    = in0_ready | in1_ready;

  // Next-state logic for the priority FSM and the output register.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_idx ? in1_data : in0_data;
      out_src_d   = grant_idx;
      state_d     = grant_idx ? PRIO0 : PRIO1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRIO0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb2x1.sv
// Directed and randomized checks for stream_arb2x1.
module tb_stream_arb2x1;

  logic       clk = 1'b0;
  logic       rst;
  logic       in0_valid, in1_valid;
  logic [7:0] in0_data, in1_data;
  logic       in0_ready, in1_ready;
  logic       out_valid, out_src, out_ready;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;

  stream_arb2x1 #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic s);
    check({tag, "_valid"}, out_valid, v);
    check({tag, "_data"},  out_data,  d);
    check({tag, "_src"},   out_src,   s);
    $display("%0t %s out_valid=%0b out_data=%02h out_src=%0b", $time, tag, out_valid, out_data, out_src);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    check({tag, "_rdy0"}, in0_ready, r0);
    check({tag, "_rdy1"}, in1_ready, r1);
  endtask

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_d;
  logic [7:0] n0, n1, d0, d1;
  logic       acc0, acc1;
  logic       src_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] dat_seq [4] = '{8'h10, 8'h20, 8'h11, 8'h21};

  initial begin
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'hEE; in1_data = 8'hDD; out_ready = 1'b1;

    // Reset: readys low regardless of valids, output cleared.
    chk_rdy("reset", 1'b0, 1'b0);
    cyc();
    chk_out("reset", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;

    // Single in0 beat, latency one cycle.
    in0_valid = 1'b1; in0_data = 8'hA5; in1_valid = 1'b0;
    chk_rdy("single", 1'b1, 1'b0);
    cyc();
    chk_out("single", 1'b1, 8'hA5, 1'b0);
    in0_valid = 1'b0;
    chk_rdy("idle", 1'b0, 1'b0);
    cyc();
    chk_out("drain", 1'b0, 8'hA5, 1'b0);

    // Fairness from PRIO0 after reset.
    rst = 1'b1; cyc(); rst = 1'b0;
    d0 = 8'h10; d1 = 8'h20;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in0_data = d0; in1_data = d1;
      chk_rdy("alt", !src_seq[i], src_seq[i]);
      cyc();
      chk_out("alt", 1'b1, dat_seq[i], src_seq[i]);
      if (src_seq[i]) d1++; else d0++;
    end

    // Stall: output holds 33 for three cycles with both inputs valid.
    in1_valid = 1'b0; in0_data = 8'h33;
    cyc();
    chk_out("load33", 1'b1, 8'h33, 1'b0);
    out_ready = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1;
    in0_data = 8'h44; in1_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("stall", 1'b0, 1'b0);
      cyc();
      chk_out("stall", 1'b1, 8'h33, 1'b0);
    end
    out_ready = 1'b1;
    chk_rdy("unstall", 1'b0, 1'b1);
    cyc();
    chk_out("unstall", 1'b1, 8'h55, 1'b1);
    in0_valid = 1'b0; in1_valid = 1'b0;
    cyc();

    // in1 only, three beats back to back, then a tie goes to in0.
    in1_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in1_data = 8'(i);
      chk_rdy("burst1", 1'b0, 1'b1);
      cyc();
      chk_out("burst1", 1'b1, 8'(i), 1'b1);
    end
    in0_valid = 1'b1; in0_data = 8'hAA; in1_data = 8'hBB;
    chk_rdy("tie", 1'b1, 1'b0);
    cyc();
    chk_out("tie", 1'b1, 8'hAA, 1'b0);

    // Mid-stream reset discards held beat 77 (loaded from in0, leaving PRIO1).
    in1_valid = 1'b0; in0_data = 8'h77;
    cyc();
    chk_out("load77", 1'b1, 8'h77, 1'b0);
    out_ready = 1'b0; rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    chk_rdy("midrst", 1'b0, 1'b0);
    cyc();
    chk_out("midrst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0; out_ready = 1'b1; in0_data = 8'h01; in1_data = 8'h02;
    chk_rdy("postrst", 1'b1, 1'b0);
    cyc();
    chk_out("postrst", 1'b1, 8'h01, 1'b0);

    // Random valid/ready stress with per-source scoreboards.
    in0_valid = 1'b0; in1_valid = 1'b0;
    cyc(); cyc();
    n0 = 8'h00; n1 = 8'h80; acc0 = 1'b0; acc1 = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      if (acc0) n0++;
      if (acc1) n1++;
      if (acc0 || !in0_valid) in0_valid = 1'($urandom_range(0, 1));
      if (acc1 || !in1_valid) in1_valid = 1'($urandom_range(0, 1));
      in0_data = n0; in1_data = n1;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("excl", in0_ready & in1_ready, 1'b0);
      check("noinv", (in0_ready & !in0_valid) | (in1_ready & !in1_valid), 1'b0);
      acc0 = in0_valid & in0_ready;
      acc1 = in1_valid & in1_ready;
      if (out_valid && out_ready) begin
        if (out_src == 1'b0) begin
          check("q0_nonempty", q0.size() != 0, 1'b1);
          if (q0.size() != 0) begin
            exp_d = q0.pop_front();
            check("q0_data", out_data, exp_d);
          end
        end else begin
          check("q1_nonempty", q1.size() != 0, 1'b1);
          if (q1.size() != 0) begin
            exp_d = q1.pop_front();
            check("q1_data", out_data, exp_d);
          end
        end
      end
      if (acc0) q0.push_back(in0_data);
      if (acc1) q1.push_back(in1_data);
      cyc();
    end
    // Drain whatever is still in flight.
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    #1;
    if (out_valid) begin
      if (out_src == 1'b0) begin
        check("drain_q0", q0.size() != 0, 1'b1);
        if (q0.size() != 0) begin
          exp_d = q0.pop_front();
          check("drain_q0_data", out_data, exp_d);
        end
      end else begin
        check("drain_q1", q1.size() != 0, 1'b1);
        if (q1.size() != 0) begin
          exp_d = q1.pop_front();
          check("drain_q1_data", out_data, exp_d);
        end
      end
    end
    cyc();
    check("end_q0_empty", q0.size(), 0);
    check("end_q1_empty", q1.size(), 0);
    check("end_idle", out_valid, 1'b0);
    $display("stress done: in0 beats up to %02h, in1 beats up to %02h", n0, n1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
